// File: rtl/max11040_frame_packer_if.sv
// Bus between the MAX11040 chain controller read path and the frame packer.
// The controller side drives the capture inputs; the packer drives frame,
// batch and error outputs.
interface max11040_frame_packer_if #(
  parameter int ADC_DCN    = 8,
  parameter int DATA_WIDTH = 8
);
  localparam int FRAME_W = ADC_DCN * 4 * 24;

  logic                  enable;
  logic                  drdy_valid;
  logic [DATA_WIDTH-1:0] byte_in;
  logic                  byte_in_valid;
  logic                  read_done;
  logic [15:0]           sample_max;
  logic [FRAME_W-1:0]    frame_data;
  logic                  frame_valid;
  logic [15:0]           sample_cnt;
  logic                  batch_done;
  logic                  busy;
  logic                  overrun_err;
  logic                  short_err;

  modport master (
    output enable, drdy_valid, byte_in, byte_in_valid, read_done, sample_max,
    input  frame_data, frame_valid, sample_cnt, batch_done, busy,
           overrun_err, short_err
  );

  modport slave (
    input  enable, drdy_valid, byte_in, byte_in_valid, read_done, sample_max,
    output frame_data, frame_valid, sample_cnt, batch_done, busy,
           overrun_err, short_err
  );
endinterface

// File: rtl/max11040_frame_packer.sv
// Collects the SPI read bytes of one MAX11040 daisy-chain conversion into a
// parallel frame (ADC_DCN devices x 4 channels x 24 bits, first byte at the
// MSB end), counts frames against a programmable batch size and flags
// overrun / short-read protocol errors. All outputs are registered.
module max11040_frame_packer #(
  parameter int ADC_DCN    = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  max11040_frame_packer_if.slave bus
);
  localparam int NBYTES  = ADC_DCN * 12;
  localparam int FRAME_W = ADC_DCN * 4 * 24;
  localparam int CNT_W   = $clog2(NBYTES + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COLLECT  = 2'd1,
    ST_WAIT_END = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [FRAME_W-1:0] frame_data_q, frame_data_d;
  logic               frame_valid_q, frame_valid_d;
  logic [15:0]        sample_cnt_q, sample_cnt_d;
  logic               batch_done_q, batch_done_d;
  logic               busy_q, busy_d;
  logic               overrun_q, overrun_d;
  logic               short_q, short_d;
  logic               frame_done_s;
  logic [FRAME_W-1:0] shifted_s;

  // Next-state, capture datapath and batch counting.
  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    shift_d       = shift_q;
    frame_data_d  = frame_data_q;
    frame_valid_d = 1'b0;
    sample_cnt_d  = sample_cnt_q;
    batch_done_d  = 1'b0;
    overrun_d     = 1'b0;
    short_d       = 1'b0;
    frame_done_s  = 1'b0;
    shifted_s     = {shift_q[FRAME_W-DATA_WIDTH-1:0], bus.byte_in};

    case (state_q)
      ST_IDLE: begin
        if (bus.drdy_valid && bus.enable) begin
          state_d    = ST_COLLECT;
          byte_cnt_d = '0;
          shift_d    = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        // A new conversion during a read is reported and dropped.
        overrun_d = bus.drdy_valid;
        if (bus.byte_in_valid && (byte_cnt_q == LAST_IDX)) begin
          shift_d      = shifted_s;
          frame_data_d = shifted_s;
          frame_done_s = 1'b1;
          byte_cnt_d   = '0;
          state_d      = bus.read_done ? ST_IDLE : ST_WAIT_END;
        end else if (bus.read_done) begin
          // Short read: partial data is discarded, frame_data left intact.
          short_d    = 1'b1;
          byte_cnt_d = '0;
          state_d    = ST_IDLE;
        end else if (bus.byte_in_valid) begin
          shift_d    = shifted_s;
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_WAIT_END: begin
        overrun_d = bus.drdy_valid;
        if (bus.read_done) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_END;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        byte_cnt_d = '0;
      end
    endcase

    if (frame_done_s) begin
      frame_valid_d = 1'b1;
      if ((bus.sample_max != 16'd0) && (sample_cnt_q == (bus.sample_max - 16'd1))) begin
        batch_done_d = 1'b1;
        sample_cnt_d = 16'd0;
      end else begin
        sample_cnt_d = sample_cnt_q + 16'd1;
      end
    end else begin
      sample_cnt_d = sample_cnt_q;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q       <= ST_IDLE;
      byte_cnt_q    <= '0;
      shift_q       <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      sample_cnt_q  <= 16'd0;
      batch_done_q  <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      short_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      shift_q       <= shift_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      sample_cnt_q  <= sample_cnt_d;
      batch_done_q  <= batch_done_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
      short_q       <= short_d;
    end
  end

  assign bus.frame_data  = frame_data_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.sample_cnt  = sample_cnt_q;
  assign bus.batch_done  = batch_done_q;
  assign bus.busy        = busy_q;
  assign bus.overrun_err = overrun_q;
  assign bus.short_err   = short_q;
endmodule

// File: tb/tb_max11040_frame_packer.sv
// Directed + randomized bench for max11040_frame_packer with ADC_DCN=2
// (24 bytes per frame, 192-bit frame). Expected frames are built by placing
// byte i at bits [191-8i -: 8]; batch counting follows the batch-size rule.
module tb_max11040_frame_packer;
  localparam int ADC_DCN = 2;
  localparam int NBYTES  = 24;
  localparam int FW      = 192;

  logic sys_clk = 1'b0;
  logic sys_rst;

  max11040_frame_packer_if #(.ADC_DCN(ADC_DCN), .DATA_WIDTH(8)) bus ();

  max11040_frame_packer #(.ADC_DCN(ADC_DCN), .DATA_WIDTH(8)) u_dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int compared   = 0;
  int mismatched = 0;

  // pulses observed on the DUT
  int fv_seen = 0, se_seen = 0, oe_seen = 0, bd_seen = 0;
  // reference model state
  int exp_fv = 0, exp_se = 0, exp_oe = 0, exp_bd = 0;
  int smax = 0;
  int exp_cnt = 0;
  bit exp_bd_now = 1'b0;
  logic [FW-1:0] exp_frame = '0;

  task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
    if (bus.frame_valid === 1'b1) fv_seen++;
    if (bus.short_err === 1'b1) se_seen++;
    if (bus.overrun_err === 1'b1) oe_seen++;
    if (bus.batch_done === 1'b1) bd_seen++;
  endtask

  // Reference: a completed frame closes a batch when it is the smax-th one.
  task automatic model_frame(input logic [FW-1:0] f);
    exp_frame = f;
    exp_fv++;
    if (smax != 0 && (exp_cnt + 1) == smax) begin
      exp_cnt = 0;
      exp_bd++;
      exp_bd_now = 1'b1;
    end else begin
      exp_cnt = (exp_cnt + 1) % 65536;
      exp_bd_now = 1'b0;
    end
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_fv_count"}, FW'(fv_seen), FW'(exp_fv));
    check({tag, "_short_count"}, FW'(se_seen), FW'(exp_se));
    check({tag, "_overrun_count"}, FW'(oe_seen), FW'(exp_oe));
    check({tag, "_batch_count"}, FW'(bd_seen), FW'(exp_bd));
  endtask

  task automatic capture(input int nbytes, input bit rd_with_last, input bit drdy_mid, input bit seq);
    logic [FW-1:0] f;
    logic [7:0] b;
    bit active, full;
    active = bus.enable;
    full = (nbytes == NBYTES);
    f = '0;
    bus.drdy_valid = 1'b1;
    step();
    bus.drdy_valid = 1'b0;
    check("busy_after_drdy", FW'(bus.busy), FW'(active));
    for (int i = 0; i < nbytes; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        bus.byte_in = 8'($urandom);
        step();
      end
      b = seq ? 8'(i + 1) : 8'($urandom);
      f[FW-1-8*i -: 8] = b;
      bus.byte_in = b;
      bus.byte_in_valid = 1'b1;
      bus.drdy_valid = drdy_mid && (i == 5);
      bus.read_done = rd_with_last && (i == nbytes - 1);
      step();
      bus.byte_in_valid = 1'b0;
      bus.drdy_valid = 1'b0;
      bus.read_done = 1'b0;
      if (drdy_mid && i == 5 && active) begin
        exp_oe++;
        check("overrun_pulse", FW'(bus.overrun_err), FW'(1));
      end
      if (i == nbytes - 1) begin
        if (active && full) begin
          model_frame(f);
          check("frame_valid_latency", FW'(bus.frame_valid), FW'(1));
          check("frame_data", bus.frame_data, exp_frame);
          check("sample_cnt_at_frame", FW'(bus.sample_cnt), FW'(exp_cnt));
          check("batch_done_at_frame", FW'(bus.batch_done), FW'(exp_bd_now));
        end else begin
          check("no_frame_valid", FW'(bus.frame_valid), FW'(0));
        end
        if (rd_with_last) begin
          if (active && !full) begin
            exp_se++;
            check("short_err_coincident", FW'(bus.short_err), FW'(1));
          end
          check("idle_after_rd_last", FW'(bus.busy), FW'(0));
        end
      end
    end
    if (!rd_with_last) begin
      if (active && full) begin
        for (int k = 0; k < 2; k++) begin
          bus.byte_in = 8'($urandom);
          bus.byte_in_valid = 1'b1;
          step();
          bus.byte_in_valid = 1'b0;
        end
        check("wait_end_busy", FW'(bus.busy), FW'(1));
      end
      bus.read_done = 1'b1;
      step();
      bus.read_done = 1'b0;
      if (active && !full) begin
        exp_se++;
        check("short_err_pulse", FW'(bus.short_err), FW'(1));
      end else begin
        check("no_short_err", FW'(bus.short_err), FW'(0));
      end
      check("idle_after_read_done", FW'(bus.busy), FW'(0));
    end
    step();
    check("frame_data_held", bus.frame_data, exp_frame);
    check("sample_cnt_held", FW'(bus.sample_cnt), FW'(exp_cnt));
    check_counts("capture");
  endtask

  initial begin
    logic [FW-1:0] fd;
    sys_rst = 1'b1;
    bus.enable = 1'b0;
    bus.drdy_valid = 1'b0;
    bus.byte_in = 8'h00;
    bus.byte_in_valid = 1'b0;
    bus.read_done = 1'b0;
    bus.sample_max = 16'd0;
    repeat (3) step();
    check("rst_frame_data", bus.frame_data, '0);
    check("rst_frame_valid", FW'(bus.frame_valid), FW'(0));
    check("rst_sample_cnt", FW'(bus.sample_cnt), FW'(0));
    check("rst_batch_done", FW'(bus.batch_done), FW'(0));
    check("rst_busy", FW'(bus.busy), FW'(0));
    check("rst_overrun", FW'(bus.overrun_err), FW'(0));
    check("rst_short", FW'(bus.short_err), FW'(0));
    sys_rst = 1'b0;
    bus.enable = 1'b1;
    smax = 0;
    bus.sample_max = 16'(smax);
    step();

    // Sequential bytes 0x01..0x18, read_done afterwards.
    capture(NBYTES, 1'b0, 1'b0, 1'b1);
    fd = bus.frame_data;
    check("first_word", FW'(fd[191:168]), FW'(24'h010203));
    check("last_word", FW'(fd[23:0]), FW'(24'h161718));
    check("sample_cnt_one", FW'(bus.sample_cnt), FW'(1));

    // read_done coincident with the last byte.
    capture(NBYTES, 1'b1, 1'b0, 1'b1);
    // Short reads: 10 bytes then read_done; 23 bytes with read_done on the last.
    capture(10, 1'b0, 1'b0, 1'b0);
    capture(NBYTES - 1, 1'b1, 1'b0, 1'b0);
    // Overrun at byte 5.
    capture(NBYTES, 1'b0, 1'b1, 1'b0);
    // Disabled: nothing starts.
    bus.enable = 1'b0;
    capture(NBYTES, 1'b0, 1'b0, 1'b0);
    bus.enable = 1'b1;

    // Reset in the middle of a capture.
    bus.drdy_valid = 1'b1;
    step();
    bus.drdy_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      bus.byte_in = 8'($urandom);
      bus.byte_in_valid = 1'b1;
      step();
    end
    bus.byte_in_valid = 1'b0;
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    exp_frame = '0;
    exp_cnt = 0;
    check("midrst_frame_data", bus.frame_data, '0);
    check("midrst_sample_cnt", FW'(bus.sample_cnt), FW'(0));
    check("midrst_busy", FW'(bus.busy), FW'(0));
    for (int i = 0; i < 12; i++) begin
      bus.byte_in = 8'($urandom);
      bus.byte_in_valid = 1'b1;
      bus.read_done = (i == 11);
      step();
    end
    bus.byte_in_valid = 1'b0;
    bus.read_done = 1'b0;
    step();
    check("midrst_busy_after", FW'(bus.busy), FW'(0));
    check_counts("midrst");

    // Batch of 3: sample_cnt 1,2,0,1 with batch_done on the third frame.
    smax = 3;
    bus.sample_max = 16'(smax);
    for (int n = 0; n < 4; n++) begin
      capture(NBYTES, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      check("batch_seq", FW'(bus.sample_cnt), FW'((n + 1) % 3));
    end

    // Randomized mix of frame lengths, batch sizes and overruns.
    for (int n = 0; n < 8; n++) begin
      int nb;
      smax = $urandom_range(0, 4);
      bus.sample_max = 16'(smax);
      nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, NBYTES - 1) : NBYTES;
      capture(nb, 1'($urandom_range(0, 1)), (nb > 5) ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
